// File: rtl/counter_32_ctrl.sv
// Command controller for counter_32_rev: loads a preset, watches RC, auto-reloads until
// the requested number of terminal events, then pulses done. Optional macro: CTRL_WRAP_CNT_EN.
module counter_32_ctrl #(
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [31:0]      cmd_preset,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic [31:0]      cnt,
  input  logic             RC,
  output logic             s,
  output logic             Load,
  output logic [31:0]      PData,
  output logic             busy,
  output logic             done,
  output logic [15:0]      wrap_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic             idle_q;
  logic             dir_q;
  logic [31:0]      preset_q;
  logic [REP_W-1:0] rem_q;
  logic             free_q;
  logic             accept;
  logic             cnt_unused;

  // abort gates ready so a blocked command is never seen as a completed handshake
  assign cmd_ready  = idle_q & ~abort;
  assign accept     = cmd_valid & cmd_ready;
  assign s          = dir_q;
  assign PData      = preset_q;
  assign cnt_unused = ^cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idle_q   <= 1'b1;
      Load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_q    <= 1'b0;
      preset_q <= '0;
      rem_q    <= '0;
      free_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dir_q    <= cmd_dir;
          preset_q <= cmd_preset;
          rem_q    <= cmd_reps;
          free_q   <= (cmd_reps == '0);
          state    <= LOAD;
          idle_q   <= 1'b0;
          Load     <= 1'b1;
          busy     <= 1'b1;
        end
        LOAD: begin
          Load <= 1'b0;
          if (abort) begin
            state  <= IDLE;
            idle_q <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state  <= IDLE;
            idle_q <= 1'b1;
            busy   <= 1'b0;
          end else if (RC) begin
            if (free_q) begin
              state <= LOAD;
              Load  <= 1'b1;
            end else if (rem_q == REP_W'(1)) begin
              rem_q <= '0;
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              rem_q <= rem_q - 1'b1;
              state <= LOAD;
              Load  <= 1'b1;
            end
          end
        end
        DONE: begin
          done   <= 1'b0;
          state  <= IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
          Load   <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CTRL_WRAP_CNT_EN
  logic        rc_hit;
  logic [15:0] wrap_q;

  // lifetime event count; survives across commands, saturating
  assign rc_hit = (state == RUN) & RC & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wrap_q <= '0;
    else if (rc_hit && wrap_q != 16'hFFFF) wrap_q <= wrap_q + 16'd1;
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_counter_32_ctrl.sv
// Bench for counter_32_ctrl: behavioural counter + transaction model, per-cycle compare,
// and directed scenarios with hand-computed latencies and pulse counts.
module tb_counter_32_ctrl;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_dir = 1'b0;
  logic [31:0]      cmd_preset = '0;
  logic [REP_W-1:0] cmd_reps = '0;
  logic             abort = 1'b0;
  logic             cmd_ready, s, Load, busy, done;
  logic [31:0]      PData, cnt;
  logic [15:0]      wrap_cnt;
  logic             RC;

  int n_cmp = 0, n_err = 0, n_load = 0, n_done = 0, lat = 0;
  bit chk_en = 0;

  counter_32_ctrl #(.REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_preset(cmd_preset), .cmd_reps(cmd_reps), .abort(abort),
    .cnt(cnt), .RC(RC), .s(s), .Load(Load), .PData(PData), .busy(busy),
    .done(done), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // stand-in for counter_32_rev
  always @(posedge clk or negedge rst_n)
    if (!rst_n)    cnt <= '0;
    else if (Load) cnt <= PData;
    else           cnt <= s ? cnt + 32'd1 : cnt - 32'd1;
  assign RC = s ? (cnt == 32'hFFFF_FFFF) : (cnt == 32'd0);

  // transaction-level model: what the controller must be doing this cycle
  bit m_load = 0, m_run = 0, m_done = 0, m_free = 0, m_dir = 0;
  int m_rem = 0, m_wrap = 0;
  logic [31:0] m_pre = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 0; m_run <= 0; m_done <= 0; m_free <= 0;
      m_dir <= 0; m_pre <= '0; m_rem <= 0; m_wrap <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_load) begin
      m_load <= 0;
      m_run  <= !abort;
    end else if (m_run) begin
      if (abort) m_run <= 0;
      else if (RC) begin
        m_run <= 0;
`ifdef CTRL_WRAP_CNT_EN
        m_wrap <= (m_wrap < 65535) ? m_wrap + 1 : m_wrap;
`endif
        if (m_free || m_rem > 1) m_load <= 1;
        else                     m_done <= 1;
        if (!m_free) m_rem <= m_rem - 1;
      end
    end else if (cmd_valid && !abort) begin
      m_dir  <= cmd_dir;
      m_pre  <= cmd_preset;
      m_rem  <= int'(cmd_reps);
      m_free <= (cmd_reps == '0);
      m_load <= 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("Load", {31'd0, Load}, {31'd0, m_load});
    chk("busy", {31'd0, busy}, {31'd0, m_load | m_run});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !(m_load | m_run | m_done) && !abort});
    chk("s", {31'd0, s}, {31'd0, m_dir});
    chk("PData", PData, m_pre);
    chk("wrap_cnt", {16'd0, wrap_cnt}, m_wrap[31:0]);
    n_load += int'(Load);
    n_done += int'(done);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic d, input logic [31:0] p, input logic [REP_W-1:0] r);
    cmd_dir = d; cmd_preset = p; cmd_reps = r; cmd_valid = 1'b1;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done && c < budget) begin cyc(1); c++; end
    chk("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1;
    #2;
    chk("rst_Load", {31'd0, Load}, 0); chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1); chk("rst_PData", PData, 0);
    chk("rst_wrap", {16'd0, wrap_cnt}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // abort in IDLE blocks acceptance
    cmd_dir = 1'b1; cmd_preset = 32'h55; cmd_reps = 8'd1; cmd_valid = 1'b1; abort = 1'b1;
    #1 chk("idle_abort_ready", {31'd0, cmd_ready}, 0);
    cyc(1);
    chk("idle_abort_busy", {31'd0, busy}, 0);
    cmd_valid = 1'b0; abort = 1'b0;
    cyc(1);

    // up count, one repetition: Load at E0, RC sampled at E4
    n_load = 0; n_done = 0;
    send(1'b1, 32'hFFFF_FFFD, 8'd1);
    wait_done(20, lat);
    chk("up_latency", lat, 4);
    cyc(2);
    chk("up_loads", n_load, 1); chk("up_dones", n_done, 1);
`ifdef CTRL_WRAP_CNT_EN
    chk("up_wrap", {16'd0, wrap_cnt}, 1);
`endif

    // down count, two repetitions with reload
    n_load = 0; n_done = 0;
    send(1'b0, 32'd3, 8'd2);
    wait_done(30, lat);
    chk("down_latency", lat, 10);
    cyc(2);
    chk("down_loads", n_load, 2); chk("down_dones", n_done, 1);
`ifdef CTRL_WRAP_CNT_EN
    chk("down_wrap", {16'd0, wrap_cnt}, 3);
`endif

    // free-run preset 1 down: Load every 3 cycles, then abort with RC high
    n_load = 0; n_done = 0;
    send(1'b0, 32'd1, 8'd0);
    cyc(8);
    chk("fr_loads", n_load, 3);
    chk("fr_rc_at_abort", {31'd0, RC}, 1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("fr_abort_busy", {31'd0, busy}, 0);
    n_load = 0;
    cyc(6);
    chk("fr_post_loads", n_load, 0); chk("fr_dones", n_done, 0);

    // back-to-back: second command held on valid during busy
    cmd_dir = 1'b1; cmd_preset = 32'hFFFF_FFFF; cmd_reps = 8'd2; cmd_valid = 1'b1;
    cyc(1);
    cmd_dir = 1'b0; cmd_preset = 32'd5; cmd_reps = 8'd1;
    wait_done(30, lat);
    chk("b2b_a_latency", lat, 4);
    cyc(1);
    chk("b2b_ready_back", {31'd0, cmd_ready}, 1);
    cyc(1);
    cmd_valid = 1'b0;
    chk("b2b_load", {31'd0, Load}, 1);
    chk("b2b_pdata", PData, 32'd5); chk("b2b_dir", {31'd0, s}, 0);
    wait_done(30, lat);
    chk("b2b_b_latency", lat, 7);
    cyc(2);

    // asynchronous reset during RUN
    send(1'b1, 32'h1234_5678, 8'd3);
    cyc(2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0); chk("mid_rst_Load", {31'd0, Load}, 0);
    chk("mid_rst_PData", PData, 0); chk("mid_rst_s", {31'd0, s}, 0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 1); chk("mid_rst_wrap", {16'd0, wrap_cnt}, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ready", {31'd0, cmd_ready}, 1);

`ifdef CTRL_WRAP_CNT_EN
    // preload near the top so saturation is reached in a few events
    dut.wrap_q = 16'hFFFC; m_wrap = 65532;
    send(1'b1, 32'hFFFF_FFFF, 8'd0);
    cyc(14);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    chk("sat_wrap", {16'd0, wrap_cnt}, 32'hFFFF);
`else
    send(1'b1, 32'hFFFF_FFFF, 8'd0);
    cyc(10);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(1);
    chk("wrap_disabled", {16'd0, wrap_cnt}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
